// File: rtl/bench_bist_pkg.sv
// Shared types and constants for the benchmark self-test driver.
package bench_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        DONE
    } state_e;

    localparam int                LFSR_W        = 16;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [LFSR_W-1:0] TAP_MASK      = 16'hB400;
    // An all-zero LFSR locks up, so a zero seed is replaced by this value.
    localparam logic [LFSR_W-1:0] SEED_FALLBACK = 16'h0001;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & TAP_MASK)};
    endfunction

endpackage

// File: rtl/bench_bist_lfsr16.sv
// 16-bit LFSR register with parallel load, step enable and a parallel XOR
// input; with xor_in tied low it is a pattern generator, otherwise a MISR.
module bench_bist_lfsr16
    import bench_bist_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              en,
    input  logic [LFSR_W-1:0] xor_in,
    output logic [LFSR_W-1:0] value,
    output logic [LFSR_W-1:0] value_nxt
);

    logic [LFSR_W-1:0] value_q;
    logic [LFSR_W-1:0] value_d;

    // Next value: load wins over a step; otherwise hold.
    always_comb begin
        // NOTE: default assignment first so no branch leaves value_d unassigned and infers a latch.
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (en) begin
            value_d = lfsr_step(value_q) ^ xor_in;
        end
    end

    // Register the value; reset clears it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign value_nxt = value_d;

endmodule

// File: rtl/bench_bist_driver.sv
// Self-test source and sink for one benchmark instance: an LFSR drives
// pseudo-random patterns, a MISR compacts the responses, and the final
// signature is compared against a golden value.
module bench_bist_driver
    import bench_bist_pkg::*;
#(
    parameter int                IN_W          = 9,
    parameter int                OUT_W         = 11,
    parameter int                PATTERN_COUNT = 256,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter int                RESP_LAT      = 1,
    parameter logic [LFSR_W-1:0] GOLDEN        = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [IN_W-1:0]   pat_out,
    output logic              pat_valid,
    output logic              dut_reset_n,
    input  logic [OUT_W-1:0]  resp_in,
    output logic              busy,
    output logic              done,
    output logic [LFSR_W-1:0] signature,
    output logic              pass
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? SEED_FALLBACK : SEED;
    // One counter serves both the RUN pattern count and the FLUSH drain count.
    localparam int CNT_MAX = (PATTERN_COUNT > RESP_LAT) ? PATTERN_COUNT : RESP_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]     pat_out_q, pat_out_d;
    logic                pat_valid_q, pat_valid_d;
    logic                dut_reset_n_q, dut_reset_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [RESP_LAT-1:0] cap_pipe_q, cap_pipe_d;
    logic [RESP_LAT-1:0] cap_shift;

    logic                enter_init;
    logic                capture_en;
    logic [LFSR_W-1:0]   pat_value, pat_nxt;
    logic [LFSR_W-1:0]   misr_value, misr_nxt;
    logic [LFSR_W-1:0]   misr_xor;
    logic                unused_pat_bits;

    // Capture pipe shifts pat_valid in at the bottom; the top bit marks a
    // response that is visible on resp_in this cycle.
    if (RESP_LAT == 1) begin : g_pipe_one
        assign cap_shift = pat_valid_q;
    end else begin : g_pipe_many
        assign cap_shift = {cap_pipe_q[RESP_LAT-2:0], pat_valid_q};
    end

    assign capture_en = cap_pipe_q[RESP_LAT-1];
    assign misr_xor   = LFSR_W'(resp_in);

    // Pattern generator: runs only in RUN, reloaded with the seed on entry to INIT.
    bench_bist_lfsr16 u_pat_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (enter_init),
        .load_val  (SEED_EFF),
        .en        (state_q == RUN),
        .xor_in    ('0),
        .value     (pat_value),
        .value_nxt (pat_nxt)
    );

    // Response compactor: cleared on entry to INIT, steps only on a capture cycle.
    bench_bist_lfsr16 u_misr (
        .clk       (clk),
        .reset     (reset),
        .load      (enter_init),
        .load_val  ('0),
        .en        (capture_en),
        .xor_in    (misr_xor),
        .value     (misr_value),
        .value_nxt (misr_nxt)
    );

    // Only the low IN_W bits of the next pattern leave the block.
    assign unused_pat_bits = ^{pat_value, pat_nxt};

    // Next-state and counter: start is honoured only from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q == CNT_W'(PATTERN_COUNT - 1)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(RESP_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the state being entered, so each
    // output lines up with its state; pattern k is on pat_out in RUN cycle k.
    always_comb begin
        enter_init    = (state_d == INIT);
        pat_valid_d   = (state_d == RUN);
        pat_out_d     = pat_valid_d ? pat_nxt[IN_W-1:0] : '0;
        busy_d        = (state_d inside {INIT, RUN, FLUSH});
        done_d        = (state_d == DONE);
        dut_reset_n_d = (state_d != INIT);
        // The last capture and the move to DONE share an edge, so compare the incoming MISR value.
        pass_d        = done_d && (misr_nxt == GOLDEN);
        cap_pipe_d    = enter_init ? '0 : cap_shift;
    end

    // Controller state and registered outputs; reset aborts any run at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pat_out_q     <= '0;
            pat_valid_q   <= 1'b0;
            dut_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            cap_pipe_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pat_out_q     <= pat_out_d;
            pat_valid_q   <= pat_valid_d;
            dut_reset_n_q <= dut_reset_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            cap_pipe_q    <= cap_pipe_d;
        end
    end

    assign pat_out     = pat_out_q;
    assign pat_valid   = pat_valid_q;
    assign dut_reset_n = dut_reset_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = misr_value;

endmodule

// File: tb/tb_bench_bist_driver.sv
// Scoreboard bench for bench_bist_driver: a default instance looped back
// through a behavioural benchmark, and a short single-pattern instance.
module tb_bench_bist_driver;

    localparam int          A_PC   = 256;
    localparam int          A_RL   = 1;
    localparam logic [15:0] A_SEED = 16'hACE1;
    localparam logic [15:0] A_GOLD = 16'h0000;
    localparam int          B_PC   = 1;
    localparam int          B_RL   = 2;
    localparam logic [15:0] B_SEED = 16'h0000;
    localparam logic [15:0] B_GOLD = 16'h0123;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    logic [8:0]  pat_out_a, pat_out_b;
    logic        pat_valid_a, pat_valid_b;
    logic        dut_reset_n_a, dut_reset_n_b;
    logic [10:0] resp_a;
    logic [10:0] resp_b = 11'd0;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] signature_a, signature_b;

    always #5 clk = ~clk;

    bench_bist_driver #(
        .IN_W(9), .OUT_W(11), .PATTERN_COUNT(A_PC), .SEED(A_SEED),
        .RESP_LAT(A_RL), .GOLDEN(A_GOLD)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .pat_out(pat_out_a), .pat_valid(pat_valid_a), .dut_reset_n(dut_reset_n_a),
        .resp_in(resp_a), .busy(busy_a), .done(done_a),
        .signature(signature_a), .pass(pass_a)
    );

    bench_bist_driver #(
        .IN_W(9), .OUT_W(11), .PATTERN_COUNT(B_PC), .SEED(B_SEED),
        .RESP_LAT(B_RL), .GOLDEN(B_GOLD)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .pat_out(pat_out_b), .pat_valid(pat_valid_b), .dut_reset_n(dut_reset_n_b),
        .resp_in(resp_b), .busy(busy_b), .done(done_b),
        .signature(signature_b), .pass(pass_b)
    );

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          done_cyc;
    } exp_res_t;

    logic [8:0] exp_pat_a[$];
    logic [8:0] exp_pat_b[$];
    exp_res_t   exp_res_a[$];
    exp_res_t   exp_res_b[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Spec rule for one register step, shared by pattern LFSR and MISR.
    function automatic logic [15:0] ref_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference run: the pattern list and the final signature. In loop mode
    // response k is the XOR of patterns 0..k (the benchmark's accumulator).
    task automatic predict(input bit to_b, input logic [15:0] seed, input int pc,
                           input bit loop, input logic [10:0] const_resp,
                           input bit flip_en, input int flip_k, input logic [10:0] flip_mask,
                           output logic [15:0] sig);
        logic [15:0] l;
        logic [15:0] m;
        logic [10:0] acc;
        logic [10:0] r;
        l   = (seed == 16'd0) ? 16'h0001 : seed;
        m   = 16'd0;
        acc = 11'd0;
        for (int k = 0; k < pc; k++) begin
            if (to_b) exp_pat_b.push_back(l[8:0]);
            else      exp_pat_a.push_back(l[8:0]);
            acc = acc ^ {2'b00, l[8:0]};
            r   = loop ? acc : const_resp;
            if (flip_en && k == flip_k) r = r ^ flip_mask;
            m = ref_step(m) ^ {5'd0, r};
            l = ref_step(l);
        end
        sig = m;
    endtask

    // Behavioural benchmark beside instance A: state ^= in, out = state.
    logic        loop_a      = 1'b0;
    logic        flip_en_a   = 1'b0;
    int          flip_k_a    = 0;
    logic [10:0] flip_mask_a = 11'd0;
    logic [10:0] bm_state;
    int          bm_cnt;

    always @(posedge clk or negedge dut_reset_n_a) begin
        if (!dut_reset_n_a) begin
            bm_state <= 11'd0;
            bm_cnt   <= 0;
        end else if (pat_valid_a) begin
            bm_state <= bm_state ^ {2'b00, pat_out_a};
            bm_cnt   <= bm_cnt + 1;
        end
    end

    assign resp_a = !loop_a ? 11'd0 :
                    bm_state ^ ((flip_en_a && (bm_cnt - 1 == flip_k_a)) ? flip_mask_a : 11'd0);

    // Monitor: pops an expected pattern for every live pattern, and an
    // expected result on every rising edge of done.
    logic     done_prev_a = 1'b0;
    logic     done_prev_b = 1'b0;
    always @(negedge clk) begin
        logic [8:0] p;
        exp_res_t   r;
        if (pat_valid_a === 1'b1) begin
            if (exp_pat_a.size() == 0) fail_now("a_pattern", $sformatf("got pattern %0h, expected none", pat_out_a));
            else begin p = exp_pat_a.pop_front(); check("a_pattern", 32'(pat_out_a), 32'(p)); end
        end
        if (done_a === 1'b1 && done_prev_a !== 1'b1) begin
            if (exp_res_a.size() == 0) fail_now("a_done", "got done, expected none");
            else begin
                r = exp_res_a.pop_front();
                check("a_signature", 32'(signature_a), 32'(r.sig));
                check("a_pass", 32'(pass_a), 32'(r.pass));
                check("a_done_cycle", cyc, r.done_cyc);
                check("a_patterns_left", exp_pat_a.size(), 0);
            end
        end
        done_prev_a = done_a;
        if (pat_valid_b === 1'b1) begin
            if (exp_pat_b.size() == 0) fail_now("b_pattern", $sformatf("got pattern %0h, expected none", pat_out_b));
            else begin p = exp_pat_b.pop_front(); check("b_pattern", 32'(pat_out_b), 32'(p)); end
        end
        if (done_b === 1'b1 && done_prev_b !== 1'b1) begin
            if (exp_res_b.size() == 0) fail_now("b_done", "got done, expected none");
            else begin
                r = exp_res_b.pop_front();
                check("b_signature", 32'(signature_b), 32'(r.sig));
                check("b_pass", 32'(pass_b), 32'(r.pass));
                check("b_done_cycle", cyc, r.done_cyc);
                check("b_patterns_left", exp_pat_b.size(), 0);
            end
        end
        done_prev_b = done_b;
    end

    task automatic check_reset_outputs();
        check("a_rst_pat_out", 32'(pat_out_a), 0);
        check("a_rst_pat_valid", 32'(pat_valid_a), 0);
        check("a_rst_busy", 32'(busy_a), 0);
        check("a_rst_done", 32'(done_a), 0);
        check("a_rst_pass", 32'(pass_a), 0);
        check("a_rst_signature", 32'(signature_a), 0);
        check("a_rst_dut_reset_n", 32'(dut_reset_n_a), 0);
        check("b_rst_busy", 32'(busy_b), 0);
        check("b_rst_done", 32'(done_b), 0);
        check("b_rst_dut_reset_n", 32'(dut_reset_n_b), 0);
    endtask

    // Issue a run on A; returns #1 after the edge that starts RUN cycle 0.
    task automatic run_a(input bit loop, input bit flip_en, input int flip_k, input logic [10:0] flip_mask);
        logic [15:0] sig;
        exp_res_t    r;
        loop_a      = loop;
        flip_en_a   = flip_en;
        flip_k_a    = flip_k;
        flip_mask_a = flip_mask;
        predict(1'b0, A_SEED, A_PC, loop, 11'd0, flip_en, flip_k, flip_mask, sig);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a    = 1'b0;
        r.sig      = sig;
        r.pass     = (sig == A_GOLD);
        r.done_cyc = cyc + 1 + A_PC + A_RL;
        exp_res_a.push_back(r);
        check("a_init_dut_reset_n", 32'(dut_reset_n_a), 0);
        check("a_init_busy", 32'(busy_a), 1);
        check("a_init_done", 32'(done_a), 0);
        check("a_init_pass", 32'(pass_a), 0);
        check("a_init_signature", 32'(signature_a), 0);
        @(posedge clk); #1;
        check("a_run0_dut_reset_n", 32'(dut_reset_n_a), 1);
        check("a_run0_pat_valid", 32'(pat_valid_a), 1);
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (exp_res_a.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
        if (exp_res_a.size() != 0) begin
            fail_now("a_done_timeout", "got no done, expected done within 3000 cycles");
            exp_res_a.delete();
            exp_pat_a.delete();
        end else begin
            check("a_done_level", 32'(done_a), 1);
            check("a_done_busy", 32'(busy_a), 0);
        end
    endtask

    task automatic run_b(input logic [10:0] rv);
        logic [15:0] sig;
        exp_res_t    r;
        resp_b = rv;
        predict(1'b1, B_SEED, B_PC, 1'b0, rv, 1'b0, 0, 11'd0, sig);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b    = 1'b0;
        r.sig      = sig;
        r.pass     = (sig == B_GOLD);
        r.done_cyc = cyc + 1 + B_PC + B_RL;
        exp_res_b.push_back(r);
        check("b_init_dut_reset_n", 32'(dut_reset_n_b), 0);
        @(posedge clk); #1;
        check("b_run0_pat_out", 32'(pat_out_b), 32'h001);
        @(posedge clk); #1;
        check("b_flush_pat_valid", 32'(pat_valid_b), 0);
        check("b_flush_busy", 32'(busy_b), 1);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (exp_res_b.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (exp_res_b.size() != 0) begin
            fail_now("b_done_timeout", "got no done, expected done within 100 cycles");
            exp_res_b.delete();
            exp_pat_b.delete();
        end
    endtask

    initial begin
        int          fk;
        logic [10:0] fm;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk); #1;
        check("a_idle_dut_reset_n", 32'(dut_reset_n_a), 1);
        check("b_idle_dut_reset_n", 32'(dut_reset_n_b), 1);

        // Responses tied low: signature stays zero and matches GOLDEN.
        run_a(1'b0, 1'b0, 0, 11'd0);
        check("a_first_pattern", 32'(pat_out_a), 32'h0E1);
        @(posedge clk); #1;
        check("a_second_pattern", 32'(pat_out_a), 32'h1C3);
        wait_done_a();

        // Loopback, with a stray start mid-run that must not disturb timing.
        run_a(1'b1, 1'b0, 0, 11'd0);
        repeat (50) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("a_midrun_busy", 32'(busy_a), 1);
        wait_done_a();

        // Restart straight from DONE: same signature again.
        run_a(1'b1, 1'b0, 0, 11'd0);
        wait_done_a();

        // One response bit flipped at a random pattern.
        fk = int'($urandom_range(0, A_PC - 1));
        fm = 11'd1 << $urandom_range(0, 10);
        run_a(1'b1, 1'b1, fk, fm);
        wait_done_a();

        // Reset during RUN cycle 100 aborts the run.
        run_a(1'b1, 1'b0, 0, 11'd0);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_pat_a.delete();
        exp_res_a.delete();
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk); #1;
        check("a_after_abort_busy", 32'(busy_a), 0);
        check("a_after_abort_done", 32'(done_a), 0);
        check("a_after_abort_dut_reset_n", 32'(dut_reset_n_a), 1);

        // Fresh run after the abort restarts the sequence.
        run_a(1'b0, 1'b0, 0, 11'd0);
        check("a_restart_first_pattern", 32'(pat_out_a), 32'h0E1);
        wait_done_a();

        // Single-pattern instance with zero seed and two-cycle latency.
        run_b(11'h123);
        wait_done_b();
        run_b(11'($urandom_range(0, 2047)));
        wait_done_b();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bench_bist_driver.md
Name: bench_bist_driver

Overview:
- Self-test source and sink for the generic sequential benchmark (9-bit `in`, 11-bit `out`, active-low async reset).
- Drives pseudo-random patterns into the benchmark inputs from a 16-bit LFSR.
- Compacts the benchmark response into a 16-bit MISR signature and compares it against a golden value.
- Sits beside each benchmark instance in the trojan-detection harness; a signature mismatch flags a modified circuit.

Parameters:
- IN_W, 9, width of the pattern bus driven to the benchmark input.
- OUT_W, 11, width of the benchmark response bus; must be 16 or less.
- PATTERN_COUNT, 256, number of patterns per run; minimum 1.
- SEED, 16'hACE1, LFSR start value; a zero value is replaced by 16'h0001.
- RESP_LAT, 1, cycles from pattern applied to response visible; minimum 1.
- GOLDEN, 16'h0000, expected final signature.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a run; sampled only in IDLE or DONE.
- pat_out  out  IN_W  pattern to the benchmark input.
- pat_valid  out  1  high while pat_out carries a live pattern.
- dut_reset_n  out  1  active-low reset to the benchmark.
- resp_in  in  OUT_W  benchmark response.
- busy  out  1  high in INIT, RUN and FLUSH.
- done  out  1  level; high in DONE.
- signature  out  16  MISR value; final once done is high.
- pass  out  1  signature==GOLDEN; valid only while done is high, 0 otherwise.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - State goes to IDLE.
  - pat_out=0, pat_valid=0, busy=0, done=0, pass=0, signature=0, dut_reset_n=0.
  - All internal counters and pipeline bits are cleared.
  - Reset asserted mid-run aborts the run immediately; no partial done.
- IDLE:
  - dut_reset_n=1 from the first cycle after reset.
  - start=1 moves to INIT.
- INIT (exactly 1 cycle):
  - dut_reset_n=0, busy=1.
  - lfsr<=SEED (or 1 if SEED is zero), misr<=0, cnt<=0, capture pipe<=0.
  - Next state is RUN.
- RUN:
  - pat_valid=1, pat_out=lfsr[IN_W-1:0], dut_reset_n=1.
  - Each cycle: lfsr advances one step and cnt increments.
  - When cnt==PATTERN_COUNT-1, next state is FLUSH. With PATTERN_COUNT=1, RUN lasts one cycle.
- LFSR step:
  - fb = l[15]^l[13]^l[12]^l[10]
  - next = {l[14:0], fb}
- Capture:
  - pat_valid is delayed RESP_LAT cycles through a shift pipe.
  - When the delayed bit is 1, misr <= {m[14:0], fbm} ^ zero-extended resp_in, where fbm uses the same taps as the LFSR on m.
  - When the delayed bit is 0, misr holds.
  - Exactly PATTERN_COUNT responses are compacted.
- FLUSH:
  - Lasts RESP_LAT cycles; pat_valid=0, pat_out=0.
  - Drains the capture pipe, then moves to DONE.
- DONE:
  - done=1, busy=0.
  - signature is frozen; pass=(misr==GOLDEN).
  - start=1 moves to INIT: done and pass drop and the MISR clears.
- start during INIT, RUN or FLUSH is ignored.
- signature tracks misr continuously; it is stable only in DONE.
- pat_out and pat_valid are registered.
  - Pattern k appears in RUN cycle k.
  - Its response is captured at cycle k+RESP_LAT.
- The counter is wide enough to hold PATTERN_COUNT without wrap.

Decomposition:
- Package bench_bist_pkg holds:
  - state enum {IDLE, INIT, RUN, FLUSH, DONE};
  - LFSR width constant 16;
  - tap mask 16'hB400 (bits 15, 13, 12, 10);
  - non-zero seed fallback constant 16'h0001.
- Sub-module bench_bist_lfsr16 performs one registered step with an optional parallel XOR input and an enable.
  - Instantiated twice: pattern generator with XOR input tied 0, and MISR.

Test Plan:
- SEED=16'hACE1, pulse start in IDLE: INIT shows dut_reset_n=0 for 1 cycle; RUN cycle 0 pat_out=9'h0E1; RUN cycle 1 pat_out=9'h1C3 (lfsr=16'h59C3); pat_valid high exactly PATTERN_COUNT cycles.
- resp_in tied 0, PATTERN_COUNT=256, GOLDEN=0: done rises at cycle 1(INIT)+256+RESP_LAT after the start sample; signature=16'h0000; pass=1.
- Loop back with a behavioural benchmark model (state^=in, out=state[10:0]): signature matches the reference-model MISR; flipping one bit of one response yields a different signature and pass=0.
- PATTERN_COUNT=1: RUN lasts 1 cycle with pat_out=9'h0E1; one capture; DONE after FLUSH.
- reset asserted at RUN cycle 100: next cycle all outputs at reset values and state IDLE; a fresh start reproduces the pattern sequence from 9'h0E1.
- start re-pulsed during RUN is ignored (cycle count unchanged); start in DONE begins a new run with identical signature; SEED=0 behaves as SEED=16'h0001 (first pat_out=9'h001).
